herring_clock_gen: RTL and testbench

//  CPU clock and reset sequencer for the Herring 6502 board; sits directly upstream of the address decoder.

---
 rtl/herring_clock_gen.sv | 162 ++++++++++++++++
 tb/tb_herring_clock_gen.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/herring_clock_gen.sv
// PHI2 generator and CPU reset sequencer for the Herring 6502 board.
// Stretches the high phase for the ACIA/VIA window and parks the clock low for single-step.
module herring_clock_gen #(
   parameter int DIV_LOW      = 4,
   parameter int DIV_HIGH     = 4,
   parameter int IO_WAIT      = 8,
   parameter int RESET_CYCLES = 16
) (
   input  logic       clk_src,
   input  logic       reset_n,
   input  logic [5:0] address,
   input  logic       step_mode,
   input  logic       step_req,
   output logic       cpu_clk_in,
   output logic       cpu_resb,
   output logic       halted
);

   typedef enum logic [1:0] {
      ST_LOW     = 2'd0,
      ST_HIGH    = 2'd1,
      ST_STRETCH = 2'd2,
      ST_HALT    = 2'd3
   } state_t;

   localparam int           IO_LAST_I  = (IO_WAIT > 0) ? IO_WAIT - 1 : 0;
   localparam logic [7:0]   LOW_LAST   = 8'(DIV_LOW - 1);
   localparam logic [7:0]   HIGH_LAST  = 8'(DIV_HIGH - 1);
   localparam logic [7:0]   IO_LAST    = 8'(IO_LAST_I);
   localparam logic [15:0]  RST_TARGET = 16'(RESET_CYCLES);
   localparam logic         STRETCH_EN = (IO_WAIT > 0);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [15:0] rst_cnt_q, rst_cnt_d;
   logic        io_sel_q, io_sel_d;
   logic        clk_q, clk_d;
   logic        resb_q, resb_d;
   logic        halted_q, halted_d;
   logic        mode_s1_q, mode_s1_d, mode_s2_q, mode_s2_d;
   logic        req_s1_q, req_s1_d, req_s2_q, req_s2_d, req_prev_q, req_prev_d;
   logic        io_hit_s, step_edge_s, step_mode_s, fall_s;

   // Next-state logic: phase counter, FSM, reset sequencer and synchronisers
   always_comb begin
      io_hit_s    = ((address & 6'b111110) == 6'b100000);
      step_mode_s = mode_s2_q;
      step_edge_s = req_s2_q & ~req_prev_q;

      mode_s1_d   = step_mode;
      mode_s2_d   = mode_s1_q;
      req_s1_d    = step_req;
      req_s2_d    = req_s1_q;
      req_prev_d  = req_s2_q;

      state_d     = state_q;
      cnt_d       = cnt_q;
      io_sel_d    = io_sel_q;
      rst_cnt_d   = rst_cnt_q;
      resb_d      = resb_q;
      fall_s      = 1'b0;

      case (state_q)
         ST_LOW: begin
            if (cnt_q == LOW_LAST) begin
               cnt_d = 8'd0;
               // Single-step only takes over once the CPU has had its reset clocks
               if (step_mode_s && resb_q) begin
                  state_d = ST_HALT;
               end else begin
                  state_d  = ST_HIGH;
                  io_sel_d = io_hit_s;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_HIGH: begin
            if (cnt_q == HIGH_LAST) begin
               cnt_d = 8'd0;
               if (io_sel_q && STRETCH_EN) begin
                  state_d = ST_STRETCH;
               end else begin
                  state_d = ST_LOW;
                  fall_s  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_STRETCH: begin
            if (cnt_q == IO_LAST) begin
               cnt_d   = 8'd0;
               state_d = ST_LOW;
               fall_s  = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_HALT: begin
            cnt_d = 8'd0;
            if (step_edge_s || !step_mode_s) begin
               state_d  = ST_HIGH;
               io_sel_d = io_hit_s;
            end else begin
               state_d = ST_HALT;
            end
         end
         default: begin
            state_d = ST_LOW;
            cnt_d   = 8'd0;
         end
      endcase

      // Count completed CPU periods; counting stops once RESB is released
      if (fall_s && !resb_q) begin
         rst_cnt_d = rst_cnt_q + 16'd1;
         resb_d    = ((rst_cnt_q + 16'd1) == RST_TARGET);
      end else begin
         rst_cnt_d = rst_cnt_q;
      end

      clk_d    = (state_d == ST_HIGH) || (state_d == ST_STRETCH);
      halted_d = (state_d == ST_HALT);
   end

   // State and output registers with asynchronous board reset
   always_ff @(posedge clk_src or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_LOW;
         cnt_q      <= 8'd0;
         rst_cnt_q  <= 16'd0;
         io_sel_q   <= 1'b0;
         clk_q      <= 1'b0;
         resb_q     <= 1'b0;
         halted_q   <= 1'b0;
         mode_s1_q  <= 1'b0;
         mode_s2_q  <= 1'b0;
         req_s1_q   <= 1'b0;
         req_s2_q   <= 1'b0;
         req_prev_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rst_cnt_q  <= rst_cnt_d;
         io_sel_q   <= io_sel_d;
         clk_q      <= clk_d;
         resb_q     <= resb_d;
         halted_q   <= halted_d;
         mode_s1_q  <= mode_s1_d;
         mode_s2_q  <= mode_s2_d;
         req_s1_q   <= req_s1_d;
         req_s2_q   <= req_s2_d;
         req_prev_q <= req_prev_d;
      end
   end

   assign cpu_clk_in = clk_q;
   assign cpu_resb   = resb_q;
   assign halted     = halted_q;

endmodule

// File: tb/tb_herring_clock_gen.sv
// Bench for herring_clock_gen: phase-length model driven by random addresses plus directed step/reset cases.
module tb_herring_clock_gen;

   localparam int DIV_LOW      = 4;
   localparam int DIV_HIGH     = 4;
   localparam int IO_WAIT      = 8;
   localparam int RESET_CYCLES = 16;

   logic       clk_src = 1'b0;
   logic       reset_n = 1'b1;
   logic [5:0] address = 6'd0;
   logic       step_mode = 1'b0;
   logic       step_req = 1'b0;
   logic       cpu_clk_in, cpu_resb, halted;

   herring_clock_gen #(
      .DIV_LOW(DIV_LOW), .DIV_HIGH(DIV_HIGH), .IO_WAIT(IO_WAIT), .RESET_CYCLES(RESET_CYCLES)
   ) dut (
      .clk_src(clk_src), .reset_n(reset_n), .address(address), .step_mode(step_mode),
      .step_req(step_req), .cpu_clk_in(cpu_clk_in), .cpu_resb(cpu_resb), .halted(halted)
   );

   always #10 clk_src = ~clk_src;

   int   checks = 0;
   int   errors = 0;
   logic prev_clk;
   int   run, falls, exp_high, last_high, since_fall;
   bit   free_run;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // Address window 0x8000-0x87FF, from the CPU's point of view
   function automatic bit is_io(input logic [5:0] a);
      logic [15:0] base;
      base = {a, 10'h000};
      return (base >= 16'h8000) && (base <= 16'h87FF);
   endfunction

   function automatic logic [5:0] rand_addr();
      case ($urandom_range(0, 3))
         0:       return 6'h20;
         1:       return 6'h21;
         2:       return 6'h22;
         default: return 6'($urandom_range(0, 63));
      endcase
   endfunction

   // One clk_src cycle: sample after the edge and compare phase lengths with the model
   task automatic tick();
      logic [5:0] a;
      a = address;
      @(posedge clk_src);
      #1;
      if (cpu_clk_in !== prev_clk) begin
         if (cpu_clk_in === 1'b1) begin
            if (free_run) check("low_len", run, DIV_LOW);
            exp_high = DIV_HIGH + (is_io(a) ? IO_WAIT : 0);
         end else begin
            check("high_len", run, exp_high);
            last_high  = run;
            falls++;
            since_fall = -1;
         end
         run = 1;
      end else begin
         run++;
      end
      since_fall++;
      check("resb", cpu_resb, (falls >= RESET_CYCLES) ? 1 : 0);
      if (free_run) check("halted_free", halted, 0);
      prev_clk = cpu_clk_in;
   endtask

   task automatic do_reset(input logic mode);
      if (reset_n !== 1'b0) reset_n = 1'b0;
      #1;
      check("rst_clk", cpu_clk_in, 0);
      check("rst_resb", cpu_resb, 0);
      check("rst_halted", halted, 0);
      step_mode = mode;
      step_req  = 1'b0;
      address   = 6'd0;
      repeat (3) @(posedge clk_src);
      #1;
      reset_n    = 1'b1;
      prev_clk   = 1'b0;
      run        = 1;
      falls      = 0;
      exp_high   = DIV_HIGH;
      last_high  = 0;
      since_fall = 0;
      free_run   = 1'b1;
   endtask

   task automatic wait_clk(input logic lvl, input string tag);
      int n;
      n = 0;
      while (cpu_clk_in !== lvl && n < 100) begin
         tick();
         n++;
      end
      check(tag, cpu_clk_in, lvl);
   endtask

   task automatic wait_halt(input string tag);
      int n;
      n = 0;
      while (halted !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      check(tag, halted, 1);
   endtask

   initial begin
      int n;
      #3;
      do_reset(1'b0);

      // Boot with address 0: period 8, RESB after 16 falls
      repeat (200) tick();
      check("resb_after_boot", cpu_resb, 1);

      address = 6'h20; repeat (40) tick();
      address = 6'h21; repeat (40) tick();
      address = 6'h22; repeat (40) tick();
      repeat (800) begin
         address = rand_addr();
         tick();
      end

      // Address leaves the I/O window during the high phase
      address = 6'h20;
      wait_clk(1'b0, "wait_low_a");
      wait_clk(1'b1, "wait_high_a");
      address = 6'h00;
      wait_clk(1'b0, "wait_low_b");
      check("midhigh_stretch", last_high, DIV_HIGH + IO_WAIT);

      // Single-step
      free_run  = 1'b0;
      step_mode = 1'b1;
      wait_halt("halt_entry");
      check("halt_low_gap", since_fall, DIV_LOW);
      repeat (6) begin
         tick();
         check("parked", {cpu_clk_in, halted}, 2'b01);
      end
      step_req = 1'b1;
      tick(); tick();
      check("step_lat2", cpu_clk_in, 0);
      tick();
      check("step_lat3", cpu_clk_in, 1);
      check("step_unhalt", halted, 0);
      step_req = 1'b0;
      tick();
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      wait_halt("rehalt");
      check("step_high", last_high, DIV_HIGH);
      check("rehalt_gap", since_fall, DIV_LOW);
      repeat (8) begin
         tick();
         check("parked_after_discard", {cpu_clk_in, halted}, 2'b01);
      end

      address  = 6'h21;
      step_req = 1'b1;
      repeat (3) tick();
      check("io_step_rise", cpu_clk_in, 1);
      step_req = 1'b0;
      address  = 6'h00;
      wait_halt("io_rehalt");
      check("io_step_high", last_high, DIV_HIGH + IO_WAIT);

      // Leaving single-step while parked
      step_mode = 1'b0;
      tick(); tick();
      check("exit_lat2", {cpu_clk_in, halted}, 2'b01);
      tick();
      check("exit_lat3", {cpu_clk_in, halted}, 2'b10);
      wait_clk(1'b0, "exit_fall");
      free_run = 1'b1;
      repeat (100) begin
         address = rand_addr();
         tick();
      end

      // Board reset while the high phase is stretched
      address = 6'h20;
      wait_clk(1'b0, "wait_low_c");
      wait_clk(1'b1, "wait_high_c");
      repeat (DIV_HIGH + 2) tick();
      check("in_stretch", cpu_clk_in, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("midstretch_clk", cpu_clk_in, 0);
      check("midstretch_resb", cpu_resb, 0);
      check("midstretch_halted", halted, 0);

      // Step mode held from reset: reset clocks still run, then halt
      do_reset(1'b1);
      n = 0;
      while (falls < RESET_CYCLES && n < 400) begin
         tick();
         n++;
      end
      check("boot_falls", falls, RESET_CYCLES);
      check("boot_resb", cpu_resb, 1);
      free_run = 1'b0;
      n = 0;
      while (halted !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check("boot_halt_gap", n, DIV_LOW);
      check("boot_halt_clk", cpu_clk_in, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
